regfile_nr1w: RTL

//  Parametrised multi-read / single-write register file; next generation of the
//  64-bit, 32-entry single-read-port register selection path.

---
 rtl/regfile_nr1w.sv | 86 ++++++++
 1 files changed

// File: rtl/regfile_nr1w.sv
// regfile_nr1w: parametrised register file with NUM_READ read ports and one write port.
// Each read port has a hardwired-zero register, an optional same-cycle write bypass
// and an optional registered output stage.
module regfile_nr1w #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 32,
    parameter int NUM_READ     = 2,
    parameter int ZERO_REG     = 31,
    parameter int BYPASS       = 1,
    parameter int READ_LATENCY = 0,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               RegWrite,
    input  logic [AW-1:0]                      WriteRegister,
    input  logic [WIDTH-1:0]                   WriteData,
    input  logic [NUM_READ-1:0][AW-1:0]        ReadRegister,
    output logic [NUM_READ-1:0][WIDTH-1:0]     ReadData
);

    // Bounds as unsigned 32-bit values so index comparisons are width-matched.
    localparam logic [31:0] DEPTH_U = DEPTH;
    localparam logic [31:0] ZERO_U  = ZERO_REG;

    // An index addresses real storage only if it is in range and is not the zero
    // register; a ZERO_REG beyond DEPTH simply never matches.
    function automatic logic is_storage(input logic [AW-1:0] idx);
        return (32'(idx) < DEPTH_U) && (32'(idx) != ZERO_U);
    endfunction

    logic [WIDTH-1:0]                 regs_r [DEPTH];
    logic                             wr_ok_s;
    logic [NUM_READ-1:0][WIDTH-1:0]   rd_v_s;

    // A write lands only when enabled and aimed at real storage.
    always_comb begin
        wr_ok_s = 1'b0;
        if (RegWrite && is_storage(WriteRegister)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Storage array: asynchronous clear, write discarded on any edge with reset high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            regs_r[WriteRegister] <= WriteData;
        end
    end

    // Per-port read value: zero register first, then bypass, then stored contents.
    always_comb begin
        rd_v_s = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            if (!is_storage(ReadRegister[p])) begin
                rd_v_s[p] = '0;
            end else if ((BYPASS != 0) && RegWrite && (ReadRegister[p] == WriteRegister)) begin
                rd_v_s[p] = WriteData;
            end else begin
                rd_v_s[p] = regs_r[ReadRegister[p]];
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign ReadData = rd_v_s;
        end else begin : g_reg_read
            // Registered read data: captures the pre-edge value (bypass included).
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ReadData <= '0;
                end else begin
                    ReadData <= rd_v_s;
                end
            end
        end
    endgenerate

endmodule
